// File: rtl/wall_blit_pkg.sv
// Shared types and constants for the wall sprite blitter.
package wall_blit_pkg;

    localparam int ADDR_W   = 19;
    localparam int SPR_W    = 32;
    localparam int SPR_H    = 66;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [1:0] TRANSPARENT = 2'd0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } blit_state_e;

endpackage

// File: rtl/wall_blit_if.sv
// Bundle of the game-logic request, sprite-memory read and frame-buffer write signals.
interface wall_blit_if;
    import wall_blit_pkg::*;

    logic              start;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic              flip_x;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] spr_addr;
    logic [1:0]        spr_data;
    // Frame-buffer write: fb_we/fb_addr/fb_data are held stable while fb_we is
    // high and fb_ready is low; the write completes on an edge where both are high.
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [1:0]        fb_data;
    logic              fb_ready;

    modport master (
        input  start, pos_x, pos_y, flip_x, spr_data, fb_ready,
        output busy, done, spr_addr, fb_we, fb_addr, fb_data
    );

    modport slave (
        output start, pos_x, pos_y, flip_x, spr_data, fb_ready,
        input  busy, done, spr_addr, fb_we, fb_addr, fb_data
    );

endinterface

// File: rtl/wall_blit_ctrl_addr_gen.sv
// Combinational sprite/frame-buffer address generation with off-screen detection.
module blit_addr_gen
    import wall_blit_pkg::*;
(
    input  logic [4:0]        sx,
    input  logic [6:0]        sy,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              flip_x,
    output logic [ADDR_W-1:0] spr_addr,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              on_screen
);

    logic [4:0]  col;
    logic [10:0] px;
    logic [10:0] py;

    always_comb begin
        col       = flip_x ? (5'(SPR_W - 1) - sx) : sx;
        spr_addr  = ADDR_W'(sy) * ADDR_W'(SPR_W) + ADDR_W'(col);
        // 11-bit sums so positions near the right/bottom edge never wrap back on-screen
        px        = {1'b0, pos_x} + 11'(sx);
        py        = {1'b0, pos_y} + 11'(sy);
        on_screen = (px < 11'(SCREEN_W)) && (py < 11'(SCREEN_H));
        fb_addr   = ADDR_W'(py) * ADDR_W'(SCREEN_W) + ADDR_W'(px);
    end

endmodule

// File: rtl/wall_blit_ctrl.sv
// Wall sprite blitter: walks the 32x66 sprite pixel by pixel (READ, WAIT, WRITE)
// and writes opaque, on-screen pixels through the frame-buffer write handshake.
module wall_blit_ctrl
    import wall_blit_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    wall_blit_if.master bus,
    output blit_state_e dbg_state
);

    blit_state_e       state_q, state_d;
    logic [4:0]        sx_q, sx_d;
    logic [6:0]        sy_q, sy_d;
    logic [9:0]        pos_x_q, pos_x_d;
    logic [9:0]        pos_y_q, pos_y_d;
    logic              flip_q, flip_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] spr_addr_q, spr_addr_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [1:0]        fb_data_q, fb_data_d;

    logic              accept;
    logic              advance;
    logic              last_px;
    logic              opaque;
    logic [ADDR_W-1:0] gen_spr_addr;
    logic [ADDR_W-1:0] gen_fb_addr;
    logic              gen_on_screen;

    // Counters and latched request; the generator sees next-cycle values so
    // spr_addr is already correct when READ begins.
    always_comb begin
        accept  = (state_q == IDLE) && bus.start;
        advance = (state_q == WRITE) && (!fb_we_q || bus.fb_ready);
        last_px = (sx_q == 5'(SPR_W - 1)) && (sy_q == 7'(SPR_H - 1));
        sx_d    = sx_q;
        sy_d    = sy_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        flip_d  = flip_q;
        if (accept) begin
            pos_x_d = bus.pos_x;
            pos_y_d = bus.pos_y;
            flip_d  = bus.flip_x;
            sx_d    = '0;
            sy_d    = '0;
        end else if (advance && !last_px) begin
            if (sx_q == 5'(SPR_W - 1)) begin
                sx_d = '0;
                sy_d = sy_q + 7'd1;
            end else begin
                sx_d = sx_q + 5'd1;
            end
        end
    end

    blit_addr_gen u_addr_gen (
        .sx        (sx_d),
        .sy        (sy_d),
        .pos_x     (pos_x_d),
        .pos_y     (pos_y_d),
        .flip_x    (flip_d),
        .spr_addr  (gen_spr_addr),
        .fb_addr   (gen_fb_addr),
        .on_screen (gen_on_screen)
    );

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        spr_addr_d = spr_addr_q;
        fb_we_d    = fb_we_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        opaque     = (bus.spr_data != TRANSPARENT);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = READ;
                    busy_d     = 1'b1;
                    spr_addr_d = gen_spr_addr;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                state_d = WRITE;
                fb_we_d = opaque && gen_on_screen;
                if (opaque && gen_on_screen) begin
                    fb_addr_d = gen_fb_addr;
                    fb_data_d = bus.spr_data;
                end
            end
            WRITE: begin
                if (advance) begin
                    fb_we_d = 1'b0;
                    if (last_px) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = READ;
                        spr_addr_d = gen_spr_addr;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            sx_q       <= '0;
            sy_q       <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            flip_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            spr_addr_q <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            flip_q     <= flip_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            spr_addr_q <= spr_addr_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.spr_addr = spr_addr_q;
    assign bus.fb_we    = fb_we_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.fb_data  = fb_data_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_wall_blit_ctrl.sv
// Directed bench for wall_blit_ctrl: table of whole-blit scenarios plus
// hand-written reset and start-rule sequences.
module tb_wall_blit_ctrl;
    import wall_blit_pkg::*;

    typedef struct {
        int px;
        int py;
        bit flip;
        int pat;          // 0: all 1, 1: addr mod 4, 2: even 0 / odd 2
        int stall;        // fb_ready low cycles at the first opaque pixel
        int exp_writes;
        int exp_first_addr;
        int exp_first_data;
        int exp_last_addr;
        int exp_done;
    } vec_t;

    logic        Clk;
    logic        Reset;
    blit_state_e dbg_state;
    wall_blit_if bus();

    wall_blit_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- sprite memory model ----------------
    logic [1:0] mem [0:2111];
    always @(posedge Clk)
        bus.spr_data <= (bus.spr_addr < 19'd2112) ? mem[int'(bus.spr_addr)] : 2'd0;

    // ---------------- scoreboard ----------------
    logic [18:0] exp_q[$];
    int n_pass = 0;
    int n_total = 0;
    int wr_cnt, bad_cnt, first_addr, first_data, last_addr;
    int cur_px, cur_py;
    int mon_row, mon_col;

    always @(negedge Clk) begin
        if (bus.fb_we === 1'b1 && bus.fb_ready === 1'b1) begin
            mon_row = int'(bus.fb_addr) / 640;
            mon_col = int'(bus.fb_addr) % 640;
            if (wr_cnt == 0) begin
                first_addr = int'(bus.fb_addr);
                first_data = int'(bus.fb_data);
            end
            last_addr = int'(bus.fb_addr);
            wr_cnt++;
            if (bus.fb_addr >= 19'd307200 || mon_col < cur_px || mon_col > cur_px + 31 ||
                mon_row < cur_py || mon_row > cur_py + 65 || bus.fb_data == 2'd0)
                bad_cnt++;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic fill_mem(input int pat);
        for (int a = 0; a < 2112; a++) begin
            case (pat)
                0:       mem[a] = 2'd1;
                1:       mem[a] = 2'(a % 4);
                default: mem[a] = (a % 2 == 1) ? 2'd2 : 2'd0;
            endcase
        end
    endtask

    // Entered #1 after a posedge with the DUT idle; returns #1 after the accept edge.
    task automatic start_blit(input int px, input int py, input bit flip);
        int sx, sy;
        wr_cnt = 0; bad_cnt = 0; first_addr = -1; first_data = -1; last_addr = -1;
        cur_px = px; cur_py = py;
        exp_q.delete();
        for (int k = 0; k < 34; k++) begin
            sy = k / 32;
            sx = k % 32;
            exp_q.push_back(19'(sy * 32 + (flip ? 31 - sx : sx)));
        end
        bus.pos_x  = 10'(px);
        bus.pos_y  = 10'(py);
        bus.flip_x = flip;
        bus.start  = 1'b1;
        @(posedge Clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Cycle 1 is the first READ cycle; returns at the negedge of the done cycle.
    task automatic wait_done(input int stall, input int glitch_at, input int done_start_at,
                             input int stall_addr, input int stall_data, output int done_cyc);
        int cyc = 1;
        int stall_left = stall;
        bit stalling = 1'b0;
        done_cyc = 0;
        while (done_cyc == 0 && cyc < 7000) begin
            @(negedge Clk);
            if (cyc == 1) check("busy_cycle1", bus.busy, 1);
            if (dbg_state == READ && exp_q.size() > 0)
                check("spr_addr_seq", bus.spr_addr, exp_q.pop_front());
            if (stall_left > 0 && (stalling || bus.fb_we)) begin
                stalling = 1'b1;
                check("stall_fb_we", bus.fb_we, 1);
                check("stall_fb_addr", bus.fb_addr, stall_addr);
                check("stall_fb_data", bus.fb_data, stall_data);
                stall_left--;
            end
            if (bus.done) begin
                done_cyc = cyc;
                check("busy_at_done", bus.busy, 0);
            end else begin
                @(posedge Clk);
                #1;
                cyc++;
                if (stall_left == 0) bus.fb_ready = 1'b1;
                bus.start = (cyc == glitch_at) || (cyc == done_start_at);
                if (cyc == glitch_at) begin
                    bus.pos_x  = 10'd100;
                    bus.pos_y  = 10'd100;
                    bus.flip_x = ~bus.flip_x;
                end
            end
        end
        if (done_cyc == 0) check("done_timeout", 0, 1);
    endtask

    // ---------------- test ----------------
    vec_t vecs[5];
    int   done_cyc;

    initial begin
        vecs[0] = '{px: 0,   py: 0,   flip: 1'b0, pat: 0, stall: 0, exp_writes: 2112,
                    exp_first_addr: 0,      exp_first_data: 1, exp_last_addr: 41631,  exp_done: 6337};
        vecs[1] = '{px: 0,   py: 0,   flip: 1'b1, pat: 1, stall: 0, exp_writes: 1584,
                    exp_first_addr: 0,      exp_first_data: 3, exp_last_addr: 41630,  exp_done: 6337};
        vecs[2] = '{px: 620, py: 470, flip: 1'b0, pat: 0, stall: 0, exp_writes: 200,
                    exp_first_addr: 301420, exp_first_data: 1, exp_last_addr: 307199, exp_done: 6337};
        vecs[3] = '{px: 0,   py: 0,   flip: 1'b0, pat: 2, stall: 0, exp_writes: 1056,
                    exp_first_addr: 1,      exp_first_data: 2, exp_last_addr: 41631,  exp_done: 6337};
        vecs[4] = '{px: 0,   py: 0,   flip: 1'b0, pat: 0, stall: 5, exp_writes: 2112,
                    exp_first_addr: 0,      exp_first_data: 1, exp_last_addr: 41631,  exp_done: 6342};

        bus.start = 1'b0; bus.pos_x = '0; bus.pos_y = '0; bus.flip_x = 1'b0;
        bus.fb_ready = 1'b1;
        wr_cnt = 0; bad_cnt = 0; cur_px = 0; cur_py = 0;
        fill_mem(0);
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        @(negedge Clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_fb_we", bus.fb_we, 0);
        check("rst_spr_addr", bus.spr_addr, 0);
        check("rst_fb_addr", bus.fb_addr, 0);
        check("rst_fb_data", bus.fb_data, 0);
        check("rst_state", dbg_state, IDLE);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            fill_mem(vecs[i].pat);
            bus.fb_ready = (vecs[i].stall == 0);
            start_blit(vecs[i].px, vecs[i].py, vecs[i].flip);
            wait_done(vecs[i].stall, 0, 0, vecs[i].exp_first_addr, vecs[i].exp_first_data, done_cyc);
            check($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
            check($sformatf("v%0d_writes", i), wr_cnt, vecs[i].exp_writes);
            check($sformatf("v%0d_first_addr", i), first_addr, vecs[i].exp_first_addr);
            check($sformatf("v%0d_first_data", i), first_data, vecs[i].exp_first_data);
            check($sformatf("v%0d_last_addr", i), last_addr, vecs[i].exp_last_addr);
            check($sformatf("v%0d_bad_writes", i), bad_cnt, 0);
            check($sformatf("v%0d_seq_left", i), exp_q.size(), 0);
            @(posedge Clk);
            @(negedge Clk);
            check($sformatf("v%0d_done_pulse", i), bus.done, 0);
            bus.fb_ready = 1'b1;
            @(posedge Clk);
            #1;
        end

        // Reset in the READ cycle of pixel 33 (cycle 100); 33 pixels already written.
        fill_mem(0);
        bus.fb_ready = 1'b1;
        start_blit(0, 0, 1'b0);
        repeat (99) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_fb_we", bus.fb_we, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_spr_addr", bus.spr_addr, 0);
        check("midrst_fb_addr", bus.fb_addr, 0);
        check("midrst_fb_data", bus.fb_data, 0);
        check("midrst_state", dbg_state, IDLE);
        repeat (10) @(posedge Clk);
        #1;
        check("midrst_writes", wr_cnt, 33);
        check("midrst_idle_busy", bus.busy, 0);

        // Restart after reset; start pulsed mid-blit (with new pos/flip) and in DONE.
        start_blit(0, 0, 1'b0);
        wait_done(0, 50, 6337, 0, 1, done_cyc);
        check("restart_done_cycle", done_cyc, 6337);
        check("restart_writes", wr_cnt, 2112);
        check("restart_first_addr", first_addr, 0);
        check("restart_last_addr", last_addr, 41631);
        check("restart_bad_writes", bad_cnt, 0);
        check("restart_seq_left", exp_q.size(), 0);
        @(posedge Clk);
        #1;
        bus.start = 1'b0;
        @(negedge Clk);
        check("start_in_done_busy", bus.busy, 0);
        check("start_in_done_state", dbg_state, IDLE);
        @(posedge Clk);
        @(negedge Clk);
        check("idle_after_done_busy", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
